mem_access_unit: RTL and testbench

- Initiator side of the data-memory interface: turns a MIPS load/store request into MemRead/MemWrite/Address/WD cycles and collects RD.
- Sits between the pipeline MEM stage and `memory`.
- Handles byte/half/word sizes, load sign/zero extension, sub-word stores by read-modify-write, and misalignment/range errors.
- The `memory` port names and timing are matched exactly:
  - write commits on the rising clk edge while MemWrite=1;
  - RD is valid in the cycle after MemRead=1 is presented with Address.

---
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory initiator: turns byte/half/word load/store requests into
// MemRead/MemWrite cycles, with sub-word stores done by read-modify-write.
module mem_access_unit #(
  parameter int WIDTH  = 32,
  parameter int DEPTHI = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [WIDTH-1:0] Address,
  output logic [WIDTH-1:0] WD,
  input  logic [WIDTH-1:0] RD
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state;
  logic        isWrite;
  logic [1:0]  sizeReg;
  logic        signedReg;
  logic [1:0]  offReg;
  logic [15:0] subData;

  logic             reqErr;
  logic [WIDTH-1:0] reqWordAddr;
  logic [7:0]       ldByte;
  logic [15:0]      ldHalf;
  logic [WIDTH-1:0] loadData;
  logic [WIDTH-1:0] laneMask;
  logic [WIDTH-1:0] laneData;
  logic [WIDTH-1:0] merged;

  assign req_ready = (state == IDLE);

  assign reqErr = (req_size == 2'b11)
                | ((req_size == SZ_HALF) && req_addr[0])
                | ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                | (|req_addr[WIDTH-1:DEPTHI+2]);

  assign reqWordAddr = WIDTH'(req_addr[DEPTHI+1:2]);

  // Load lane extraction from the word returned by memory
  assign ldByte = RD[{offReg, 3'b000} +: 8];
  assign ldHalf = RD[{offReg[1], 4'b0000} +: 16];

  always_comb begin
    loadData = RD;
    case (sizeReg)
      SZ_BYTE: loadData = {{(WIDTH-8){signedReg & ldByte[7]}}, ldByte};
      SZ_HALF: loadData = {{(WIDTH-16){signedReg & ldHalf[15]}}, ldHalf};
      default: loadData = RD;
    endcase
  end

  // Sub-word store: replicate the new value across lanes, then mask it in
  assign laneMask = (sizeReg == SZ_BYTE) ? (WIDTH'(8'hFF)    << {offReg, 3'b000})
                                         : (WIDTH'(16'hFFFF) << {offReg[1], 4'b0000});
  assign laneData = (sizeReg == SZ_BYTE) ? {(WIDTH/8){subData[7:0]}} : {(WIDTH/16){subData}};
  assign merged   = (RD & ~laneMask) | (laneData & laneMask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      isWrite    <= 1'b0;
      sizeReg    <= 2'b00;
      signedReg  <= 1'b0;
      offReg     <= 2'b00;
      subData    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Address    <= '0;
      WD         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            isWrite   <= req_write;
            sizeReg   <= req_size;
            signedReg <= req_signed;
            offReg    <= req_addr[1:0];
            subData   <= req_wdata[15:0];
            if (reqErr) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state   <= ISSUE;
              Address <= reqWordAddr;
              if (req_write && (req_size == SZ_WORD)) begin
                MemWrite <= 1'b1;
                WD       <= req_wdata;
              end else begin
                MemRead <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          if (isWrite && (sizeReg == SZ_WORD)) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            Address    <= '0;
            WD         <= '0;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (isWrite) begin
            state    <= WRITE;
            MemWrite <= 1'b1;
            WD       <= merged;
          end else begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_rdata <= loadData;
            Address    <= '0;
          end
        end
        WRITE: begin
          state      <= DONE;
          MemWrite   <= 1'b0;
          WD         <= '0;
          Address    <= '0;
          resp_valid <= 1'b1;
        end
        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural memory on the
// MemRead/MemWrite port.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WD;
    logic [31:0] RD = '0;

    int total = 0;
    int bad = 0;
    int bothCnt = 0;
    int addrChanges = 0;

    logic [31:0] mem [0:65535];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (MemWrite) mem[Address[15:0]] <= WD;
        if (MemRead)  RD <= mem[Address[15:0]];
    end

    mem_access_unit #(.WIDTH(32), .DEPTHI(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WD(WD), .RD(RD)
    );

    task automatic chk(input string tag, input logic ok,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          lat, rdCnt, wrCnt;
    logic [31:0] wdSeen, adrSeen, rdata;
    logic        err;

    // Drives one request, follows it to resp_valid and checks the return to IDLE.
    task automatic runReq(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d);
        logic haveAdr;
        @(negedge clk);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        chk("ready_before_accept", req_ready === 1'b1, req_ready, 1'b1);
        lat = 0; rdCnt = 0; wrCnt = 0; wdSeen = '0; adrSeen = '0; rdata = '0; err = 1'b0;
        haveAdr = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            if (MemRead && MemWrite) bothCnt++;
            if (MemRead) rdCnt++;
            if (MemWrite) begin wrCnt++; wdSeen = WD; end
            if (MemRead || MemWrite) begin
                if (haveAdr && (Address != adrSeen)) addrChanges++;
                adrSeen = Address; haveAdr = 1'b1;
            end
            if (resp_valid) begin
                lat = i; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        @(negedge clk);
        chk("after_done_valid", resp_valid === 1'b0, resp_valid, 1'b0);
        chk("after_done_rdata", resp_rdata === 32'h0, resp_rdata, 32'h0);
        chk("after_done_ready", req_ready === 1'b1, req_ready, 1'b1);
    endtask

    task automatic expectLoad(input string tag, input logic [31:0] expData);
        $display("load %s: lat=%0d rdata=%h err=%b", tag, lat, rdata, err);
        chk({tag, "_lat"}, lat === 3, lat, 3);
        chk({tag, "_rdata"}, rdata === expData, rdata, expData);
        chk({tag, "_err"}, err === 1'b0, err, 1'b0);
        chk({tag, "_rdcnt"}, rdCnt === 1, rdCnt, 1);
        chk({tag, "_wrcnt"}, wrCnt === 0, wrCnt, 0);
    endtask

    task automatic expectErr(input string tag);
        $display("error %s: lat=%0d rdata=%h err=%b", tag, lat, rdata, err);
        chk({tag, "_lat"}, lat === 1, lat, 1);
        chk({tag, "_err"}, err === 1'b1, err, 1'b1);
        chk({tag, "_rdata"}, rdata === 32'h0, rdata, 32'h0);
        chk({tag, "_memcycles"}, (rdCnt + wrCnt) === 0, rdCnt + wrCnt, 0);
    endtask

    initial begin
        int cyc;
        logic sawWrite, sawResp;

        repeat (2) @(negedge clk);
        chk("rst_valid", resp_valid === 1'b0, resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata === 32'h0, resp_rdata, 32'h0);
        chk("rst_err", resp_err === 1'b0, resp_err, 1'b0);
        chk("rst_memread", MemRead === 1'b0, MemRead, 1'b0);
        chk("rst_memwrite", MemWrite === 1'b0, MemWrite, 1'b0);
        chk("rst_address", Address === 32'h0, Address, 32'h0);
        chk("rst_wd", WD === 32'h0, WD, 32'h0);
        chk("rst_ready", req_ready === 1'b1, req_ready, 1'b1);
        rst = 1'b0;

        runReq(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
        $display("sw 0x14: lat=%0d wd=%h adr=%h", lat, wdSeen, adrSeen);
        chk("sw_lat", lat === 2, lat, 2);
        chk("sw_wrcnt", wrCnt === 1, wrCnt, 1);
        chk("sw_rdcnt", rdCnt === 0, rdCnt, 0);
        chk("sw_wd", wdSeen === 32'hDEADBEEF, wdSeen, 32'hDEADBEEF);
        chk("sw_addr", adrSeen === 32'h5, adrSeen, 32'h5);
        chk("sw_err", err === 1'b0, err, 1'b0);
        chk("sw_mem", mem[5] === 32'hDEADBEEF, mem[5], 32'hDEADBEEF);

        runReq(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        chk("lw_addr", adrSeen === 32'h5, adrSeen, 32'h5);
        expectLoad("lw0", 32'hDEADBEEF);

        runReq(1'b1, 2'b10, 1'b0, 32'h14, 32'h8899AABB);
        chk("sw2_lat", lat === 2, lat, 2);
        runReq(1'b0, 2'b00, 1'b1, 32'h15, 32'h0);  expectLoad("lb15", 32'hFFFFFFAA);
        runReq(1'b0, 2'b00, 1'b0, 32'h15, 32'h0);  expectLoad("lbu15", 32'h000000AA);
        runReq(1'b0, 2'b01, 1'b1, 32'h16, 32'h0);  expectLoad("lh16", 32'hFFFF8899);
        runReq(1'b0, 2'b01, 1'b0, 32'h14, 32'h0);  expectLoad("lhu14", 32'h0000AABB);
        runReq(1'b0, 2'b00, 1'b1, 32'h17, 32'h0);  expectLoad("lb17", 32'hFFFFFF88);
        runReq(1'b0, 2'b10, 1'b1, 32'h14, 32'h0);  expectLoad("lwsigned", 32'h8899AABB);

        runReq(1'b1, 2'b00, 1'b0, 32'h17, 32'hFFFFFF5A);
        $display("sb 0x17: lat=%0d rd=%0d wr=%0d wd=%h", lat, rdCnt, wrCnt, wdSeen);
        chk("sb_lat", lat === 4, lat, 4);
        chk("sb_rdcnt", rdCnt === 1, rdCnt, 1);
        chk("sb_wrcnt", wrCnt === 1, wrCnt, 1);
        chk("sb_wd", wdSeen === 32'h5A99AABB, wdSeen, 32'h5A99AABB);
        chk("sb_addr", adrSeen === 32'h5, adrSeen, 32'h5);
        runReq(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);  expectLoad("lw_after_sb", 32'h5A99AABB);

        runReq(1'b1, 2'b01, 1'b1, 32'h14, 32'h1234CAFE);
        $display("sh 0x14: lat=%0d wd=%h", lat, wdSeen);
        chk("sh_lat", lat === 4, lat, 4);
        chk("sh_wd", wdSeen === 32'h5A99CAFE, wdSeen, 32'h5A99CAFE);
        runReq(1'b0, 2'b00, 1'b0, 32'h14, 32'h0);  expectLoad("lbu14", 32'h000000FE);

        runReq(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);        expectErr("lh_misalign");
        runReq(1'b0, 2'b10, 1'b0, 32'h16, 32'h0);        expectErr("lw_misalign");
        runReq(1'b1, 2'b11, 1'b0, 32'h14, 32'h0);        expectErr("size11");
        runReq(1'b0, 2'b10, 1'b0, 32'h00040000, 32'h0);  expectErr("range");
        chk("mem_after_errors", mem[5] === 32'h5A99CAFE, mem[5], 32'h5A99CAFE);

        // Backpressure: lw then lbu with req_valid held continuously
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h14; req_valid = 1'b1;
        chk("bp_ready_a", req_ready === 1'b1, req_ready, 1'b1);
        @(negedge clk);
        req_size = 2'b00;
        cyc = 1;
        while (!resp_valid && cyc < 10) begin
            chk("bp_ready_busy", req_ready === 1'b0, req_ready, 1'b0);
            @(negedge clk);
            cyc++;
        end
        $display("bp first: lat=%0d rdata=%h", cyc, resp_rdata);
        chk("bp_a_lat", cyc === 3, cyc, 3);
        chk("bp_a_rdata", resp_rdata === 32'h5A99CAFE, resp_rdata, 32'h5A99CAFE);
        chk("bp_ready_done", req_ready === 1'b0, req_ready, 1'b0);
        @(negedge clk);
        chk("bp_ready_idle", req_ready === 1'b1, req_ready, 1'b1);
        chk("bp_idle_memread", MemRead === 1'b0, MemRead, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_b_issue", MemRead === 1'b1, MemRead, 1'b1);
        cyc = 1;
        while (!resp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        $display("bp second: lat=%0d rdata=%h", cyc, resp_rdata);
        chk("bp_b_lat", cyc === 3, cyc, 3);
        chk("bp_b_rdata", resp_rdata === 32'h000000FE, resp_rdata, 32'h000000FE);
        @(negedge clk);
        @(negedge clk);
        chk("bp_no_third", MemRead === 1'b0, MemRead, 1'b0);

        // Reset during CAPTURE of a halfword RMW
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b01; req_addr = 32'h14; req_wdata = 32'h1234; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_issue_read", MemRead === 1'b1, MemRead, 1'b1);
        @(negedge clk);
        chk("rmw_capture_read", MemRead === 1'b0, MemRead, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstmid_memwrite", MemWrite === 1'b0, MemWrite, 1'b0);
        chk("rstmid_memread", MemRead === 1'b0, MemRead, 1'b0);
        chk("rstmid_address", Address === 32'h0, Address, 32'h0);
        chk("rstmid_wd", WD === 32'h0, WD, 32'h0);
        chk("rstmid_valid", resp_valid === 1'b0, resp_valid, 1'b0);
        chk("rstmid_ready", req_ready === 1'b1, req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        sawWrite = 1'b0; sawResp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (MemWrite) sawWrite = 1'b1;
            if (resp_valid) sawResp = 1'b1;
        end
        $display("reset mid-rmw: mem[5]=%h", mem[5]);
        chk("rstmid_no_write", sawWrite === 1'b0, sawWrite, 1'b0);
        chk("rstmid_no_resp", sawResp === 1'b0, sawResp, 1'b0);
        chk("rstmid_mem", mem[5] === 32'h5A99CAFE, mem[5], 32'h5A99CAFE);

        chk("never_both", bothCnt === 0, bothCnt, 0);
        chk("addr_stable", addrChanges === 0, addrChanges, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
